priority_encoder_8to3: RTL and testbench

Registered 8-to-3 priority encoder. It reports the index of the highest-set bit of an 8-bit request vector, plus a valid flag. Two independent encoders run in parallel on the same input: a behavioural one, which drives the outputs, and a gate-level structural one, which acts as a self-check. Their registered results are compared every cycle. The block sits in front of arbitration/interrupt logic that needs a one-cycle-registered "highest active requester" index.

---
 rtl/priority_encoder_pkg.sv | 18 +
 rtl/priority_encoder_if.sv | 31 +++
 rtl/priority_encoder_behav.sv | 29 ++
 rtl/priority_encoder_struct.sv | 28 ++
 rtl/priority_encoder_8to3.sv | 52 +++++
 tb/tb_priority_encoder_8to3.sv | 138 +++++++++++++
 6 files changed

// File: rtl/priority_encoder_pkg.sv
// Shared widths, the no-request index and the result bundle used by the
// registered 8-to-3 priority encoder and its self-check path.
package priority_encoder_pkg;

    localparam int IN_W  = 8;
    localparam int OUT_W = 3;

    // Index reported when no request bit is set; valid distinguishes it from bit 0.
    localparam logic [OUT_W-1:0] NO_REQ_IDX = 3'b000;

    typedef struct packed {
        logic [OUT_W-1:0] idx;
        logic             valid;
    } enc_result_t;

    localparam enc_result_t ENC_RESET = '{idx: NO_REQ_IDX, valid: 1'b0};

endpackage : priority_encoder_pkg

// File: rtl/priority_encoder_if.sv
// Request vector and registered encoder results. There is no handshake:
// `in` is sampled on every rising clk edge, and the results follow one cycle later.
interface priority_encoder_if;
    import priority_encoder_pkg::*;

    logic [IN_W-1:0]  in;
    logic [OUT_W-1:0] out;
    logic             valid;
    logic [OUT_W-1:0] out_struct;
    logic             valid_struct;
    logic             mismatch;

    modport master (
        output in,
        input  out,
        input  valid,
        input  out_struct,
        input  valid_struct,
        input  mismatch
    );

    modport slave (
        input  in,
        output out,
        output valid,
        output out_struct,
        output valid_struct,
        output mismatch
    );

endinterface : priority_encoder_if

// File: rtl/priority_encoder_behav.sv
// Behavioural priority encoder: casez chain from bit 7 (highest) down to bit 0.
module priority_encoder_behav
    import priority_encoder_pkg::*;
(
    input  logic [IN_W-1:0]  in,
    output logic [OUT_W-1:0] out,
    output logic             valid
);

    always_comb begin
        out   = NO_REQ_IDX;
        valid = 1'b1;
        casez (in)
            8'b1???????: out = 3'd7;
            8'b01??????: out = 3'd6;
            8'b001?????: out = 3'd5;
            8'b0001????: out = 3'd4;
            8'b00001???: out = 3'd3;
            8'b000001??: out = 3'd2;
            8'b0000001?: out = 3'd1;
            8'b00000001: out = 3'd0;
            default: begin
                out   = NO_REQ_IDX;
                valid = 1'b0;
            end
        endcase
    end

endmodule : priority_encoder_behav

// File: rtl/priority_encoder_struct.sv
// Gate-level priority encoder built from AND/OR/NOT only; an independent
// implementation of the same function, used to cross-check the behavioural path.
module priority_encoder_struct
    import priority_encoder_pkg::*;
(
    input  logic [IN_W-1:0]  in,
    output logic [OUT_W-1:0] out,
    output logic             valid
);

    logic n2, n4, n5, n6;

    assign n2 = ~in[2];
    assign n4 = ~in[4];
    assign n5 = ~in[5];
    assign n6 = ~in[6];

    assign out[2] = in[7] | in[6] | in[5] | in[4];
    assign out[1] = in[7] | in[6] | (n5 & n4 & (in[3] | in[2]));
    // Each term is guarded by the inverted higher bits that would otherwise override it.
    assign out[0] = in[7]
                  | (n6 & in[5])
                  | (n6 & n4 & in[3])
                  | (n6 & n4 & n2 & in[1]);

    assign valid = |in;

endmodule : priority_encoder_struct

// File: rtl/priority_encoder_8to3.sv
// Registered 8-to-3 priority encoder: the behavioural result drives out/valid,
// the structural result is registered alongside and compared every cycle.
module priority_encoder_8to3
    import priority_encoder_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    priority_encoder_if.slave  bus
);

    enc_result_t behav_comb;
    enc_result_t struct_comb;
    logic        mismatch_comb;

    enc_result_t behav_q;
    enc_result_t struct_q;
    logic        mismatch_q;

    priority_encoder_behav u_behav (
        .in    (bus.in),
        .out   (behav_comb.idx),
        .valid (behav_comb.valid)
    );

    priority_encoder_struct u_struct (
        .in    (bus.in),
        .out   (struct_comb.idx),
        .valid (struct_comb.valid)
    );

    // Compare the two encoders on the same sample, before either is registered.
    assign mismatch_comb = |(behav_comb ^ struct_comb);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            behav_q    <= ENC_RESET;
            struct_q   <= ENC_RESET;
            mismatch_q <= 1'b0;
        end else begin
            behav_q    <= behav_comb;
            struct_q   <= struct_comb;
            mismatch_q <= mismatch_comb;
        end
    end

    assign bus.out          = behav_q.idx;
    assign bus.valid        = behav_q.valid;
    assign bus.out_struct   = struct_q.idx;
    assign bus.valid_struct = struct_q.valid;
    assign bus.mismatch     = mismatch_q;

endmodule : priority_encoder_8to3

// File: tb/tb_priority_encoder_8to3.sv
// Directed bench for the registered 8-to-3 priority encoder.
module tb_priority_encoder_8to3;
    import priority_encoder_pkg::*;

    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;

    priority_encoder_if bus ();

    priority_encoder_8to3 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Clock: period 10, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [2:0] ref_idx(input logic [7:0] v);
        logic [2:0] r;
        r = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (v[i]) r = 3'(i);
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [2:0] exp_out, input logic exp_valid);
        vectors++;
        assert (bus.out === exp_out) else begin
            miscompares++;
            $error("FAIL %s out: got %0d expected %0d", tag, bus.out, exp_out);
        end
        vectors++;
        assert (bus.valid === exp_valid) else begin
            miscompares++;
            $error("FAIL %s valid: got %0b expected %0b", tag, bus.valid, exp_valid);
        end
        vectors++;
        assert (bus.out_struct === exp_out) else begin
            miscompares++;
            $error("FAIL %s out_struct: got %0d expected %0d", tag, bus.out_struct, exp_out);
        end
        vectors++;
        assert (bus.valid_struct === exp_valid) else begin
            miscompares++;
            $error("FAIL %s valid_struct: got %0b expected %0b", tag, bus.valid_struct, exp_valid);
        end
        vectors++;
        assert (bus.mismatch === 1'b0) else begin
            miscompares++;
            $error("FAIL %s mismatch: got %0b expected 0", tag, bus.mismatch);
        end
    endtask

    // Drive on the falling edge, sample 1 time unit after the next rising edge.
    task automatic step(input logic [7:0] v);
        @(negedge clk);
        bus.in = v;
        @(posedge clk);
        #1;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;

        // Reset asserted with all requests high: outputs must be zero immediately.
        rst_n  = 1'b0;
        bus.in = 8'hFF;
        #1;
        check("reset_immediate", 3'd0, 1'b0);
        @(posedge clk);
        #1;
        check("reset_hold", 3'd0, 1'b0);

        // Release on a falling edge with no requests.
        @(negedge clk);
        rst_n  = 1'b1;
        bus.in = 8'h00;
        @(posedge clk);
        #1;
        check("release_zero", 3'd0, 1'b0);

        // One-hot sweep.
        for (int k = 0; k < 8; k++) begin
            logic [7:0] v;
            v = 8'h01 << k;
            step(v);
            check($sformatf("onehot_%0d", k), 3'(k), 1'b1);
        end

        // Multiple bits set: highest wins.
        step(8'b1100_0000); check("multi_c0", 3'd7, 1'b1);
        step(8'b0111_0000); check("multi_70", 3'd6, 1'b1);
        step(8'b0001_1000); check("multi_18", 3'd4, 1'b1);
        step(8'b0000_0011); check("multi_03", 3'd1, 1'b1);
        step(8'b0010_1010); check("multi_2a", 3'd5, 1'b1);
        step(8'b0000_1100); check("multi_0c", 3'd3, 1'b1);
        step(8'b0000_0101); check("multi_05", 3'd2, 1'b1);

        // Exhaustive, back-to-back against the reference model.
        for (int i = 0; i < 256; i++) begin
            logic [7:0] v;
            v = 8'(i);
            step(v);
            check($sformatf("exh_%02h", v), ref_idx(v), v != 8'h00);
        end

        // Mid-stream reset pulsed between edges.
        step(8'h80);
        check("pre_reset_80", 3'd7, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("midstream_reset", 3'd0, 1'b0);
        @(posedge clk);
        #1;
        check("midstream_hold", 3'd0, 1'b0);
        @(negedge clk);
        rst_n  = 1'b1;
        bus.in = 8'h20;
        @(posedge clk);
        #1;
        check("post_reset_20", 3'd5, 1'b1);

        // Zero after activity.
        step(8'hFF); check("zero_after_ff", 3'd7, 1'b1);
        step(8'h00); check("zero_after_00", 3'd0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_priority_encoder_8to3
